// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes, status codes and length helper
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                         I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                         I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [2:0] STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  typedef enum logic [1:0] {NX_DONE, NX_REG, NX_CONST} next_cls_e;
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    return (icode inside {I_HALT, I_NOP, I_RET}) ? 4'd1 :
           (icode inside {I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) ? 4'd2 :
           (icode inside {I_JXX, I_CALL}) ? 4'd9 :
           (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) ? 4'd10 : 4'd0;
  endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: byte-wide instruction memory request/response bus
interface fetch_seq_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        mem_err;
  modport master(output mem_req, mem_addr, input mem_rdata, mem_valid, mem_err);
  modport slave(input mem_req, mem_addr, output mem_rdata, mem_valid, mem_err);
endinterface

// File: rtl/instr_valid_chk.sv
// instr_valid_chk: icode/ifun legality and the byte class that follows the opcode
module instr_valid_chk
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       legal,
  output next_cls_e  cls
);
  always_comb begin
    legal = (icode inside {I_RRMOVQ, I_JXX}) ? (ifun <= 4'd6) :
            (icode == I_OPQ) ? (ifun <= 4'd3) :
            (icode <= I_POPQ) ? (ifun == 4'd0) : 1'b0;
    cls = (icode inside {I_HALT, I_NOP, I_RET}) ? NX_DONE :
          (icode inside {I_JXX, I_CALL}) ? NX_CONST : NX_REG;
  end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: SEQ fetch stage; owns the PC and fetches one instruction byte per beat
module fetch_seq
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_seq_if.master       mem,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [63:0]       valC,
  output logic [63:0]       valP,
  output logic [63:0]       pc,
  output logic              out_valid,
  input  logic              pc_load,
  input  logic [63:0]       new_pc,
  output logic [2:0]        stat
);
  typedef enum logic [2:0] {F_OP, F_REG, F_CONST, DONE, STOP} state_e;
  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d, valc_q, valc_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [2:0]  cnt_q, cnt_d, stat_q, stat_d;
  logic        legal, fetching, accept, has_reg;
  logic [3:0]  off;
  next_cls_e   cls;
  instr_valid_chk u_chk (.icode(mem.mem_rdata[7:4]), .ifun(mem.mem_rdata[3:0]), .legal(legal), .cls(cls));
  assign fetching = state_q inside {F_OP, F_REG, F_CONST};
  assign accept = fetching && mem.mem_valid;
  assign has_reg = icode_q inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ};
  // constant bytes follow the opcode, or the register byte when one exists
  assign off = (state_q == F_REG) ? 4'd1 :
               (state_q == F_CONST) ? (has_reg ? 4'd2 : 4'd1) + {1'b0, cnt_q} : 4'd0;
  assign mem.mem_req = rst_n && fetching;
  assign mem.mem_addr = pc_q + {60'd0, off};
  assign icode = icode_q;
  assign ifun = ifun_q;
  assign rA = ra_q;
  assign rB = rb_q;
  assign valC = valc_q;
  assign pc = pc_q;
  assign stat = stat_q;
  assign out_valid = state_q inside {DONE, STOP};
  assign valP = out_valid ? pc_q + {60'd0, instr_len(icode_q)} : 64'd0;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    icode_d = icode_q;
    ifun_d = ifun_q;
    ra_d = ra_q;
    rb_d = rb_q;
    valc_d = valc_q;
    cnt_d = cnt_q;
    stat_d = stat_q;
    if (accept && mem.mem_err) begin
      stat_d = STAT_ADR;
      state_d = STOP;
    end else if (accept) begin
      case (state_q)
        F_OP: begin
          icode_d = mem.mem_rdata[7:4];
          ifun_d = mem.mem_rdata[3:0];
          stat_d = !legal ? STAT_INS : (mem.mem_rdata[7:4] == I_HALT) ? STAT_HLT : STAT_AOK;
          state_d = !legal ? STOP : (cls == NX_DONE) ? DONE : (cls == NX_REG) ? F_REG : F_CONST;
        end
        F_REG: begin
          ra_d = mem.mem_rdata[7:4];
          rb_d = mem.mem_rdata[3:0];
          state_d = has_reg ? F_CONST : DONE;
        end
        F_CONST: begin
          valc_d[{cnt_q, 3'b000} +: 8] = mem.mem_rdata;
          cnt_d = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? DONE : F_CONST;
        end
        default: ;
      endcase
    end else if (state_q == DONE && pc_load) begin
      if (icode_q == I_HALT) state_d = STOP;
      else begin
        state_d = F_OP;
        pc_d = new_pc;
        icode_d = 4'd0;
        ifun_d = 4'd0;
        ra_d = RNONE;
        rb_d = RNONE;
        valc_d = 64'd0;
        cnt_d = 3'd0;
        stat_d = STAT_AOK;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_OP;
      pc_q <= RESET_PC;
      icode_q <= 4'd0;
      ifun_q <= 4'd0;
      ra_q <= RNONE;
      rb_q <= RNONE;
      valc_q <= 64'd0;
      cnt_q <= 3'd0;
      stat_q <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      icode_q <= icode_d;
      ifun_q <= ifun_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      valc_q <= valc_d;
      cnt_q <= cnt_d;
      stat_q <= stat_d;
    end
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized fetch bench with a memory responder and a byte-level decode model
module tb_fetch_seq;
  import y86_pkg::*;
  localparam logic [63:0] RST = 64'h0;
  logic        clk = 1'b0, rst_n = 1'b0, pc_load = 1'b0, out_valid;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp, pc, new_pc = 64'd0;
  logic [2:0]  stat;
  fetch_seq_if bus();
  fetch_seq #(.RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
    .valC(valc), .valP(valp), .pc(pc), .out_valid(out_valid), .pc_load(pc_load),
    .new_pc(new_pc), .stat(stat)
  );
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  logic [7:0]  imem [256];
  int lim [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  bit          err_en = 1'b0, stopped = 1'b1, prev_stall = 1'b0, stall;
  logic [63:0] err_addr = 64'd0, base_pc = 64'd0, prev_addr = 64'd0;
  int          beat = 0, waits = 0, rand_wait = 0, stall_beat = -1, stall_left = 0;
  logic [3:0]  e_ic, e_fn, e_ra, e_rb;
  logic [63:0] e_valc, e_valp;
  logic [2:0]  e_stat;
  int          e_beats;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // memory slave: optional wait states, fault at err_addr, and address-sequence checks
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 8'd0;
    bus.mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (prev_stall) chk("addr_hold", bus.mem_addr, prev_addr);
        stall = (beat == stall_beat && stall_left > 0) || ($urandom_range(99) < rand_wait);
        if (beat == stall_beat && stall_left > 0) stall_left--;
        bus.mem_valid = !stall;
        bus.mem_rdata = imem[bus.mem_addr[7:0]];
        bus.mem_err = err_en && bus.mem_addr == err_addr;
        if (!stall) begin
          chk("addr_seq", bus.mem_addr, base_pc + 64'(beat));
          beat++;
        end else waits++;
        prev_stall = stall;
        prev_addr = bus.mem_addr;
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_err = 1'b0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic put(input logic [63:0] p, input logic [79:0] b);
    logic [63:0] a;
    for (int i = 0; i < 10; i++) begin
      a = p + 64'(i);
      imem[a[7:0]] = b[79 - 8 * i -: 8];
    end
  endtask

  task automatic model(input logic [63:0] p);
    logic [63:0] a;
    logic [7:0]  b0, b1;
    int len, erri, off;
    bit legal;
    b0 = imem[p[7:0]];
    a = p + 64'd1;
    b1 = imem[a[7:0]];
    legal = int'(b0[3:0]) <= lim[b0[7:4]];
    len = legal ? len_tab[b0[7:4]] : 1;
    erri = -1;
    for (int k = len - 1; k >= 0; k--) if (err_en && err_addr == p + 64'(k)) erri = k;
    e_ic = b0[7:4];
    e_fn = b0[3:0];
    e_ra = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
    e_rb = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
    e_valc = 64'd0;
    if (len >= 9) begin
      off = (len == 10) ? 2 : 1;
      for (int i = 0; i < 8; i++) begin
        a = p + 64'(off + i);
        e_valc[8 * i +: 8] = imem[a[7:0]];
      end
    end
    e_valp = p + 64'(len);
    e_stat = (erri >= 0) ? STAT_ADR : !legal ? STAT_INS : (b0[7:4] == I_HALT) ? STAT_HLT : STAT_AOK;
    e_beats = (erri >= 0) ? erri + 1 : len;
  endtask

  task automatic run(input logic [63:0] p);
    int reqs;
    model(p);
    beat = 0;
    waits = 0;
    base_pc = p;
    reqs = 0;
    if (stopped) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_pc", pc, RST);
      chk("rst_valid", out_valid, 0);
      chk("rst_stat", stat, STAT_AOK);
      chk("rst_icode", icode, 0);
      chk("rst_ra", ra, 4'hF);
      chk("rst_rb", rb, 4'hF);
      chk("rst_valc", valc, 0);
      chk("rst_valp", valp, 0);
      chk("rst_req", bus.mem_req, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      @(negedge clk);
      pc_load = 1'b1;
      new_pc = p;
      @(negedge clk);
      pc_load = 1'b0;
    end
    for (int c = 0; c < 300 && !out_valid; c++) begin
      if (bus.mem_req) reqs++;
      pc_load = rand_wait > 0 && $urandom_range(3) == 0;
      new_pc = {$urandom, $urandom};
      @(negedge clk);
    end
    pc_load = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("stat", stat, e_stat);
    chk("pc", pc, p);
    chk("latency", 64'(reqs), 64'(e_beats + waits));
    if (e_stat == STAT_AOK || e_stat == STAT_HLT) begin
      chk("icode", icode, e_ic);
      chk("ifun", ifun, e_fn);
      chk("rA", ra, e_ra);
      chk("rB", rb, e_rb);
      chk("valC", valc, e_valc);
      chk("valP", valp, e_valp);
    end
    stopped = e_stat != STAT_AOK;
    if (stopped) begin
      repeat (3) begin
        pc_load = 1'b1;
        new_pc = {$urandom, $urandom};
        @(negedge clk);
        chk("stop_req", bus.mem_req, 0);
        chk("stop_pc", pc, p);
        chk("stop_valid", out_valid, 1);
      end
      pc_load = 1'b0;
      chk("stop_stat", stat, e_stat);
    end
  endtask

  task automatic dir(input logic [63:0] p_req, input logic [79:0] b, input int err_off);
    logic [63:0] p;
    p = stopped ? RST : p_req;
    put(p, b);
    err_en = err_off >= 0;
    err_addr = p + 64'(err_off);
    run(p);
    err_en = 1'b0;
  endtask

  initial begin
    logic [79:0] b;
    logic [3:0]  ic;
    for (int i = 0; i < 256; i++) imem[i] = 8'h10;
    dir(64'h0, 80'h30F2EFCDAB8967452301, -1);
    chk("irmovq_valc", valc, 64'h0123456789ABCDEF);
    dir(64'h10, 80'h71000100000000000000, -1);
    chk("jle_valp", valp, 64'h19);
    dir(64'hFFFF_FFFF_FFFF_FFFC, 80'h80112233445566778800, -1);
    chk("wrap_valp", valp, 64'h5);
    stall_beat = 1;
    stall_left = 3;
    dir(64'h40, 80'h60230000000000000000, -1);
    chk("stall_waits", 64'(waits), 64'd3);
    stall_beat = -1;
    put(64'h100, 80'h30F2EFCDAB8967452301);
    beat = 0;
    base_pc = 64'h100;
    @(negedge clk);
    pc_load = 1'b1;
    new_pc = 64'h100;
    @(negedge clk);
    pc_load = 1'b0;
    for (int c = 0; c < 50 && beat < 6; c++) begin
      @(negedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, RST);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_valc", valc, 0);
    chk("midrst_req", bus.mem_req, 0);
    stopped = 1'b1;
    dir(64'h0, 80'hC0000000000000000000, -1);
    dir(64'h0, 80'h27000000000000000000, -1);
    dir(64'h0, 80'h50123300000000000000, 2);
    dir(64'h0, 80'h00000000000000000000, -1);
    rand_wait = 30;
    repeat (60) begin
      b = {$urandom, $urandom, 16'($urandom)};
      if ($urandom_range(99) < 85) begin
        ic = 4'($urandom_range(11));
        b[79:72] = {ic, 4'($urandom_range(lim[ic]))};
      end
      dir({56'd0, 8'($urandom)}, b, ($urandom_range(9) == 0) ? int'($urandom_range(9)) : -1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Sequential instruction-fetch front end for the Y86-64 SEQ core.
- Owns the architectural PC. It fetches the instruction at PC one byte at a time from a byte-wide instruction memory.
- Splits each instruction into icode/ifun/rA/rB/valC and computes valP.
- When the instruction commits, it loads the next-PC value computed downstream and starts the next fetch.
- It is the consumer of new_pc and the producer of valC/valP for the PC-selection logic.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  byte read request
- mem_addr  out  64  byte address; stable while mem_req is high and mem_valid is low
- mem_rdata  in  8  read data; valid when mem_valid is high
- mem_valid  in  1  beat accepted when mem_req and mem_valid are both high (same-cycle response allowed)
- mem_err  in  1  qualified by mem_valid; address fault
- icode  out  4  decoded instruction code
- ifun  out  4  decoded function code
- rA  out  4  register A; 4'hF if the instruction has no register byte
- rB  out  4  register B; 4'hF if the instruction has no register byte
- valC  out  64  little-endian constant; 0 if the instruction has none
- valP  out  64  PC + instruction length
- pc  out  64  current architectural PC
- out_valid  out  1  decoded fields stable and valid
- pc_load  in  1  commit strobe from writeback; sampled only while out_valid is high
- new_pc  in  64  next PC, sampled with pc_load
- stat  out  3  AOK=1, HLT=2, ADR=3, INS=4

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - pc = RESET_PC; state = F_OP.
  - mem_req = 0 for that cycle; out_valid = 0; stat = AOK.
  - icode = ifun = 0; rA = rB = F; valC = 0; valP = 0; byte counter = 0.
  - Any partially collected bytes are discarded.
- States: F_OP, F_REG, F_CONST, DONE, STOP.
- F_OP:
  - mem_req = 1, mem_addr = pc.
  - On accept: icode = byte[7:4], ifun = byte[3:0].
  - Legal icode/ifun: icode 0,1,9 need ifun 0; icode 2 and 7 need ifun 0-6; icode 6 needs ifun 0-3; icode 3,4,5,8,A,B need ifun 0.
  - Illegal (icode > B or bad ifun) -> stat INS, go to STOP.
  - Legal, next state by icode: 0,1,9 -> DONE; 2,3,4,5,6,A,B -> F_REG; 7,8 -> F_CONST.
- F_REG:
  - mem_addr = pc + 1.
  - On accept: rA = byte[7:4], rB = byte[3:0].
  - icode 3,4,5 -> F_CONST; otherwise -> DONE.
- F_CONST:
  - mem_addr = pc + base + cnt, where base = 2 for icode 3/4/5 and 1 for icode 7/8.
  - On each accept, the byte goes to valC[8*cnt +: 8] and cnt increments.
  - After cnt = 7 is accepted -> DONE.
- valP = pc + length. Lengths: 1 for icode 0,1,9; 2 for 2,6,A,B; 9 for 7,8; 10 for 3,4,5. 64-bit wrap-around arithmetic; no overflow flag.
- mem_err with mem_valid in any fetch state: stat ADR, go to STOP; that byte is discarded.
- DONE:
  - out_valid = 1 starting the cycle after the final byte is accepted; all outputs are held.
  - pc_load = 1 -> pc = new_pc, out_valid falls, fields clear, state = F_OP, and the next mem_req is issued in the following cycle.
  - icode 0 (halt) in DONE: stat = HLT, out_valid = 1 once; pc_load then moves the block to STOP instead of F_OP.
- STOP:
  - mem_req = 0 permanently; pc frozen.
  - out_valid = 1 with the faulting stat (ADR/INS/HLT) so writeback can observe it.
  - pc_load ignored; only reset exits.
- pc_load outside DONE (and outside the out_valid phase) is ignored.
- Wait states: while mem_valid = 0, the state, cnt and mem_addr are unchanged.
- Zero-wait latency: an N-byte instruction takes N request cycles, then out_valid on cycle N+1.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ);
  - stat codes (STAT_AOK/HLT/ADR/INS);
  - RNONE = 4'hF;
  - the function instr_len(icode).
- State enum lives locally in fetch_seq.
- One sub-module, instr_valid_chk: combinational icode/ifun legality plus next-state class. Reusable by a later PIPE fetch.

Test Plan:
- irmovq: bytes 30 F2 EF CD AB 89 67 45 23 01 at pc 0, zero wait -> after 10 accepts, out_valid = 1 with icode 3, ifun 0, rA F, rB 2, valC 64'h0123456789ABCDEF, valP 0x0A. Then pc_load with new_pc 0x0A -> mem_addr 0x0A on the next request.
- jle 0x100 at pc 0x10: bytes 71 00 01 00 00 00 00 00 00 -> icode 7, ifun 1, rA = rB = F, valC 0x100, valP 0x19. pc_load new_pc 0x100 -> next fetch at 0x100.
- Wait states: hold mem_valid = 0 for 3 cycles on the F_REG byte of 60 23 (addq) -> mem_addr stays pc + 1. Result: icode 6, rA 2, rB 3, valP pc + 2, out_valid after 5 cycles.
- Errors:
  - byte 0xC0 -> stat INS after 1 accept, mem_req = 0 forever, pc_load ignored.
  - byte 0x27 -> stat INS.
  - mem_err on the 3rd byte of 50 … -> stat ADR.
- Halt: byte 00 -> out_valid, stat HLT, valP pc + 1. After pc_load, STOP holds with no further mem_req.
- Reset mid-F_CONST (after 4 constant bytes) -> immediately pc = RESET_PC, out_valid = 0, valC = 0. After release, the first mem_addr is RESET_PC.
